// File: rtl/dds_pkg.sv
// Shared encodings and constants for the DDS waveform generator.
// The wave select encodings match the cfg_wave field of the configuration bus.
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'b00,
    WAVE_SQUARE = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_SAW    = 2'b11
  } wave_e;

  localparam logic [15:0]        AMP_UNITY = 16'h8000;
  localparam int                 AMP_FRAC  = $clog2(AMP_UNITY);
  localparam logic signed [15:0] SQ_POS    = 16'sd32767;
  localparam logic signed [15:0] SQ_NEG    = -16'sd32767;
  localparam logic signed [17:0] SAT_MAX   = 18'sd32767;
  localparam logic signed [17:0] SAT_MIN   = -18'sd32768;

  // Clamp a scaled sample to the Q1.15 range instead of letting it wrap.
  function automatic logic signed [15:0] sat16(input logic signed [17:0] y);
    if (y > SAT_MAX)      return 16'sh7fff;
    else if (y < SAT_MIN) return 16'sh8000;
    else                  return y[15:0];
  endfunction

endpackage

// File: rtl/dds_sine_quarter_lut.sv
// Quarter-wave sine magnitude ROM with a registered address.
// Entry k holds round(32767*sin(pi/2*(k+0.5)/2^LUT_AW)), built at elaboration.
module dds_sine_quarter_lut #(
  parameter int LUT_AW = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [LUT_AW-1:0] addr,
  output logic [14:0]       mag
);

  localparam int N = 2 ** LUT_AW;

  // Fixed-point (Q30) Taylor series; the terms shrink far below one LSB by i=7.
  function automatic logic [14:0] lut_entry(input int k);
    longint x, x2, term, acc;
    x    = (64'sd1686629713 * longint'(2 * k + 1)) / longint'(2 * N);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int i = 1; i <= 7; i++) begin
      term = -((term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1));
      acc += term;
    end
    return 15'((acc * 64'sd32767 + 64'sd536870912) >>> 30);
  endfunction

  logic [14:0]       rom [N];
  logic [LUT_AW-1:0] addr_q;

  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam logic [14:0] ENTRY = lut_entry(k);
    assign rom[k] = ENTRY;
  end

  // NOTE: the address register carries no reset; it only holds datapath
  // state that is qualified by a valid bit downstream.
  always_ff @(posedge clk) begin
    if (en) addr_q <= addr;
  end

  assign mag = rom[addr_q];

endmodule

// File: rtl/dds_waveform_gen.sv
// DDS source: phase accumulator, four shapes, amplitude scaling with saturation.
// Shape/amplitude changes are held pending and applied at accumulator wrap.
module dds_waveform_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_en,
  input  logic               phase_clr,
  input  logic               cfg_we,
  input  logic [PHASE_W-1:0] cfg_ftw,
  input  logic [1:0]         cfg_wave,
  input  logic [15:0]        cfg_amp,
  output logic               cfg_pending,
  output logic [15:0]        data_out,
  output logic               data_valid
);

  localparam int MSB = PHASE_W - 1;

  logic [PHASE_W-1:0] phase, ftw;
  logic [PHASE_W:0]   phase_sum;
  wave_e              act_wave, pend_wave;
  logic [15:0]        act_amp, pend_amp;
  logic               advance, wrap, apply_now;

  assign advance   = sample_en & ~phase_clr;
  assign phase_sum = {1'b0, phase} + {1'b0, ftw};
  assign wrap      = advance & phase_sum[PHASE_W];
  // An idle accumulator never wraps, so pending settings would otherwise stall.
  assign apply_now = wrap | phase_clr | (ftw == '0);

  // NOTE: every clocked process uses non-blocking assignments so that all
  // registers sample pre-edge values (e.g. the accumulator sees the old ftw).
  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= '0;
      ftw         <= '0;
      act_wave    <= WAVE_SINE;
      act_amp     <= '0;
      pend_wave   <= WAVE_SINE;
      pend_amp    <= '0;
      cfg_pending <= 1'b0;
    end else begin
      if (phase_clr)      phase <= '0;
      else if (sample_en) phase <= phase_sum[PHASE_W-1:0];

      if (cfg_we) begin
        ftw <= cfg_ftw;
        if (apply_now) begin
          act_wave    <= wave_e'(cfg_wave);
          act_amp     <= cfg_amp;
          cfg_pending <= 1'b0;
        end else begin
          pend_wave   <= wave_e'(cfg_wave);
          pend_amp    <= cfg_amp;
          cfg_pending <= 1'b1;
        end
      end else if (cfg_pending && apply_now) begin
        act_wave    <= pend_wave;
        act_amp     <= pend_amp;
        cfg_pending <= 1'b0;
      end
    end
  end

  // Stage 1: shape of the current phase.
  logic [LUT_AW-1:0]  lut_addr;
  logic [15:0]        tri_t;
  logic signed [15:0] raw_shape;
  logic [14:0]        sine_mag;

  always_comb begin
    lut_addr = phase[MSB-2 -: LUT_AW];
    if (phase[MSB-1]) lut_addr = ~lut_addr;
    tri_t = phase[MSB] ? ~phase[MSB-1 -: 16] : phase[MSB-1 -: 16];
    unique case (act_wave)
      WAVE_SQUARE: raw_shape = phase[MSB] ? SQ_NEG : SQ_POS;
      WAVE_TRI:    raw_shape = signed'(tri_t ^ 16'h8000);
      WAVE_SAW:    raw_shape = signed'({~phase[MSB], phase[MSB-1 -: 15]});
      default:     raw_shape = '0;  // sine comes from the ROM one stage later
    endcase
  end

  dds_sine_quarter_lut #(.LUT_AW(LUT_AW)) u_sine_lut (
    .clk  (clk),
    .en   (advance),
    .addr (lut_addr),
    .mag  (sine_mag)
  );

  logic               s1_valid, s1_neg;
  wave_e              s1_wave;
  logic [15:0]        s1_amp;
  logic signed [15:0] s1_shape;

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= advance;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_wave  <= act_wave;
      s1_amp   <= act_amp;
      s1_neg   <= phase[MSB];
      s1_shape <= raw_shape;
    end
  end

  // Stage 2: amplitude scaling with floor shift and saturation.
  logic signed [15:0] shape;
  logic signed [32:0] product;
  logic signed [17:0] scaled;

  always_comb begin
    if (s1_wave == WAVE_SINE)
      shape = s1_neg ? -signed'({1'b0, sine_mag}) : signed'({1'b0, sine_mag});
    else
      shape = s1_shape;
    product = 33'(shape) * signed'({17'b0, s1_amp});
    scaled  = 18'(product >>> AMP_FRAC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      data_valid <= s1_valid;
      if (s1_valid) data_out <= sat16(scaled);
    end
  end

endmodule

// File: tb/tb_dds_waveform_gen.sv
// Directed bench for dds_waveform_gen with hand-computed sample values.
module tb_dds_waveform_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en = 1'b0;
  logic        phase_clr = 1'b0;
  logic        cfg_we = 1'b0;
  logic [31:0] cfg_ftw = '0;
  logic [1:0]  cfg_wave = '0;
  logic [15:0] cfg_amp = '0;
  logic        cfg_pending;
  logic [15:0] data_out;
  logic        data_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  dds_waveform_gen dut (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (sample_en),
    .phase_clr   (phase_clr),
    .cfg_we      (cfg_we),
    .cfg_ftw     (cfg_ftw),
    .cfg_wave    (cfg_wave),
    .cfg_amp     (cfg_amp),
    .cfg_pending (cfg_pending),
    .data_out    (data_out),
    .data_valid  (data_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_cfg(input logic [31:0] f, input logic [1:0] w, input logic [15:0] a);
    cfg_we = 1'b1; cfg_ftw = f; cfg_wave = w; cfg_amp = a;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Issue exp_q.size() strobes, one every `stride` cycles, and check each
  // valid lands exactly two cycles after its strobe with the expected value.
  task automatic run_samples(input string tag, input int stride);
    int n = exp_q.size();
    int last = 0;
    bit have_last = 1'b0;
    for (int c = 0; c < n * stride + 2; c++) begin
      sample_en = (c % stride == 0) && (c / stride < n);
      @(negedge clk);
      if (c >= 1 && ((c - 1) % stride == 0) && ((c - 1) / stride < n)) begin
        check({tag, " valid"}, int'(data_valid), 1);
        check({tag, " data"}, int'($signed(data_out)), exp_q[(c - 1) / stride]);
        last = exp_q[(c - 1) / stride];
        have_last = 1'b1;
      end else begin
        check({tag, " idle"}, int'(data_valid), 0);
        if (have_last) check({tag, " hold"}, int'($signed(data_out)), last);
      end
    end
    sample_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    do_reset();
    check("reset valid", int'(data_valid), 0);
    check("reset data", int'($signed(data_out)), 0);
    check("reset pending", int'(cfg_pending), 0);

    // Sine, quarter-cycle steps, strobes spaced three cycles apart.
    write_cfg(32'h4000_0000, 2'b00, 16'h8000);
    check("sine cfg direct", int'(cfg_pending), 0);
    exp_q = {101, 32767, -101, -32767};
    run_samples("sine", 3);

    // Square at half gain, back-to-back strobes.
    do_reset();
    write_cfg(32'h8000_0000, 2'b01, 16'h4000);
    exp_q = {16383, -16384, 16383, -16384};
    run_samples("square", 1);

    do_reset();
    write_cfg(32'h1000_0000, 2'b11, 16'h8000);
    exp_q = {-32768, -28672, -24576};
    run_samples("saw", 1);

    do_reset();
    write_cfg(32'h1000_0000, 2'b10, 16'h8000);
    exp_q = {-32768, -24576, -16384, -8192, 0, 8192, 16384, 24576, 32767, 24575};
    run_samples("tri", 1);

    // Gain just under 2.0 must clamp, not wrap.
    do_reset();
    write_cfg(32'h8000_0000, 2'b01, 16'hFFFF);
    exp_q = {32767, -32768};
    run_samples("sat", 1);

    // Shape change requested mid-cycle waits for the wrap.
    do_reset();
    write_cfg(32'h2000_0000, 2'b00, 16'h8000);
    exp_q = {101, 23241};
    run_samples("pend pre", 1);
    write_cfg(32'h2000_0000, 2'b01, 16'h8000);
    check("pend set", int'(cfg_pending), 1);
    exp_q = {32767, 23099, -101, -23241, -32767};
    run_samples("pend sine", 1);
    check("pend held", int'(cfg_pending), 1);
    exp_q = {-23099};
    run_samples("pend last", 1);
    check("pend cleared", int'(cfg_pending), 0);
    exp_q = {32767, 32767};
    run_samples("pend square", 1);

    // Reset mid-stream discards the sample in flight.
    do_reset();
    write_cfg(32'h4000_0000, 2'b00, 16'h8000);
    sample_en = 1'b1;
    repeat (2) @(negedge clk);
    check("mid valid before rst", int'(data_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; sample_en = 1'b0;
    check("mid rst valid", int'(data_valid), 0);
    check("mid rst data", int'($signed(data_out)), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid no stale valid", int'(data_valid), 0);
    end

    // phase_clr wins over sample_en and restarts at phase 0.
    write_cfg(32'h4000_0000, 2'b01, 16'h8000);
    exp_q = {32767, 32767};
    run_samples("clr pre", 1);
    phase_clr = 1'b1; sample_en = 1'b1;
    @(negedge clk);
    phase_clr = 1'b0; sample_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("clr no valid", int'(data_valid), 0);
    end
    exp_q = {32767};
    run_samples("clr post", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
